// File: rtl/otter_rf_wb_arbiter_if.sv
// Write-back port bundle between the OTTER write-back producers/issue stage and the arbiter.
// Latency: none (wires only); all timing is defined by otter_rf_wb_arbiter.
// Backpressure: REQ_VALID/REQ_READY per requester; requesters hold VALID/RD/DATA until READY.
//
// Signals (N_REQ requesters, XLEN data width):
//   REQ_VALID/REQ_READY  per-requester handshake, READY is one-hot or zero
//   REQ_RD   5*N_REQ     destination of requester i at [5i+4:5i]
//   REQ_DATA XLEN*N_REQ  data of requester i at [XLEN*i+XLEN-1:XLEN*i]
//   RSV_EN/RSV_RD        issue stage reserving a destination register
//   RS1/RS2, BUSY1/BUSY2 hazard query for the instruction in issue
//   WB_EN/WB_RD/WB_DATA  registered register-file write port
//   PEND                 scoreboard vector (debug)
//   FWD1_*/FWD2_*        same-cycle forwarding, present only with OTTER_WB_BYPASS_EN
// Modports: master = producers + issue stage, slave = arbiter.
interface otter_rf_wb_arbiter_if #(
  parameter int N_REQ = 3,
  parameter int XLEN  = 32
);
  logic [N_REQ-1:0]      REQ_VALID;
  logic [N_REQ-1:0]      REQ_READY;
  logic [5*N_REQ-1:0]    REQ_RD;
  logic [XLEN*N_REQ-1:0] REQ_DATA;
  logic                  RSV_EN;
  logic [4:0]            RSV_RD;
  logic [4:0]            RS1;
  logic [4:0]            RS2;
  logic                  BUSY1;
  logic                  BUSY2;
  logic                  WB_EN;
  logic [4:0]            WB_RD;
  logic [XLEN-1:0]       WB_DATA;
  logic [31:0]           PEND;
`ifdef OTTER_WB_BYPASS_EN
  logic                  FWD1_VALID;
  logic                  FWD2_VALID;
  logic [XLEN-1:0]       FWD1_DATA;
  logic [XLEN-1:0]       FWD2_DATA;
`endif

  modport master (
    output REQ_VALID, REQ_RD, REQ_DATA, RSV_EN, RSV_RD, RS1, RS2,
`ifdef OTTER_WB_BYPASS_EN
    input  FWD1_VALID, FWD2_VALID, FWD1_DATA, FWD2_DATA,
`endif
    input  REQ_READY, BUSY1, BUSY2, WB_EN, WB_RD, WB_DATA, PEND
  );

  modport slave (
    input  REQ_VALID, REQ_RD, REQ_DATA, RSV_EN, RSV_RD, RS1, RS2,
`ifdef OTTER_WB_BYPASS_EN
    output FWD1_VALID, FWD2_VALID, FWD1_DATA, FWD2_DATA,
`endif
    output REQ_READY, BUSY1, BUSY2, WB_EN, WB_RD, WB_DATA, PEND
  );
endinterface

// File: rtl/otter_rf_wb_arbiter.sv
// Round-robin arbiter for the OTTER register-file write port plus a RAW-hazard scoreboard.
// Latency: 1 cycle from acceptance (VALID & READY at posedge) to WB_EN/WB_RD/WB_DATA; one write per cycle.
// Backpressure: at most one requester gets READY per cycle; losers hold their request, READY is 0 in reset.
//
// Ports:
//   CLK  system clock, all state on posedge
//   RST  synchronous active-high reset
//   bus  otter_rf_wb_arbiter_if.slave (requests, reservation, hazard query, write port, PEND)
// Optional feature macro: OTTER_WB_BYPASS_EN adds FWD1_*/FWD2_* forwarding of the value being
// accepted this cycle and masks the matching BUSY output, removing the post-write-back stall.
// The interface instance must be built with the same N_REQ and XLEN as this module.
module otter_rf_wb_arbiter #(
  parameter int N_REQ   = 3,
  parameter int XLEN    = 32,
  parameter int RST_PTR = 0
) (
  input logic                  CLK,
  input logic                  RST,
  otter_rf_wb_arbiter_if.slave bus
);

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  typedef logic [PW-1:0] ptr_t;

  // Round-robin state and combinational grant
  ptr_t             ptr_q;
  ptr_t             ptr_nxt;
  ptr_t             grant_idx;
  logic             grant_vld;
  logic             xfer;
  logic [N_REQ-1:0] ready;

  // Payload of the granted requester
  logic [4:0]       sel_rd;
  logic [XLEN-1:0]  sel_data;

  // Registered write port and scoreboard
  logic             wb_en_q;
  logic [4:0]       wb_rd_q;
  logic [XLEN-1:0]  wb_data_q;
  logic [31:0]      pend_q;
  logic [31:0]      pend_nxt;

  // Search from the pointer, wrapping modulo N_REQ; the first valid requester wins.
  always_comb begin
    int idx;
    idx       = 0;
    grant_vld = 1'b0;
    grant_idx = '0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = (int'(ptr_q) + k) % N_REQ;
      if (!grant_vld && bus.REQ_VALID[ptr_t'(idx)]) begin
        grant_vld = 1'b1;
        grant_idx = ptr_t'(idx);
      end
    end
  end

  // READY is suppressed during reset so nothing can be accepted and then lost.
  always_comb begin
    ready = '0;
    if (grant_vld && !RST) begin
      ready[grant_idx] = 1'b1;
    end
  end

  assign xfer          = grant_vld && !RST;
  assign bus.REQ_READY = ready;

  // One-hot mux of the winner's destination and data.
  always_comb begin
    sel_rd   = '0;
    sel_data = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (ready[i]) begin
        sel_rd   = bus.REQ_RD[5*i +: 5];
        sel_data = bus.REQ_DATA[XLEN*i +: XLEN];
      end
    end
  end

  // The granted requester drops to lowest priority next cycle.
  assign ptr_nxt = (grant_idx == ptr_t'(N_REQ - 1)) ? '0 : grant_idx + ptr_t'(1);

  // Clear first, then set: a reservation in the same cycle as the write-back of the same
  // register belongs to a newer producer and must stay outstanding.
  always_comb begin
    pend_nxt = pend_q;
    if (xfer) begin
      pend_nxt[sel_rd] = 1'b0;
    end
    if (bus.RSV_EN && (bus.RSV_RD != 5'd0)) begin
      pend_nxt[bus.RSV_RD] = 1'b1;
    end
    pend_nxt[0] = 1'b0;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      wb_en_q   <= 1'b0;
      wb_rd_q   <= 5'd0;
      wb_data_q <= '0;
      pend_q    <= 32'd0;
      ptr_q     <= ptr_t'(RST_PTR);
    end else begin
      // x0 writes are accepted (they free the requester) but never enable the register file.
      wb_en_q <= xfer && (sel_rd != 5'd0);
      if (xfer) begin
        wb_rd_q   <= sel_rd;
        wb_data_q <= sel_data;
        ptr_q     <= ptr_nxt;
      end
      pend_q <= pend_nxt;
    end
  end

  assign bus.WB_EN   = wb_en_q;
  assign bus.WB_RD   = wb_rd_q;
  assign bus.WB_DATA = wb_data_q;
  assign bus.PEND    = pend_q;

  // BUSY looks at the scoreboard before the current edge; PEND[0] is never set, so x0 is never busy.
`ifdef OTTER_WB_BYPASS_EN
  logic fwd1;
  logic fwd2;

  assign fwd1 = xfer && (bus.RS1 != 5'd0) && (sel_rd == bus.RS1);
  assign fwd2 = xfer && (bus.RS2 != 5'd0) && (sel_rd == bus.RS2);

  assign bus.FWD1_VALID = fwd1;
  assign bus.FWD2_VALID = fwd2;
  assign bus.FWD1_DATA  = sel_data;
  assign bus.FWD2_DATA  = sel_data;

  assign bus.BUSY1 = pend_q[bus.RS1] && !fwd1;
  assign bus.BUSY2 = pend_q[bus.RS2] && !fwd2;
`else
  assign bus.BUSY1 = pend_q[bus.RS1];
  assign bus.BUSY2 = pend_q[bus.RS2];
`endif

endmodule
